// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The master side issues start with operands; the slave side reports busy/done and the result.
interface serial_subtractor_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [N-1:0] D;
  logic         Bo;

  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Bo
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Bo
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin (mod 2**N), Bo = 1 when A < B + Bin.
// One full-subtractor cell processes the latched operands LSB-first, one bit
// per clock, with the running borrow kept in a single flop. The FSM walks
// IDLE -> SHIFT (N edges) -> DONE -> IDLE; D/Bo update only on leaving DONE.
module serial_subtractor #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter value seen on the last SHIFT edge of an operation.
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  state_t        state;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [N-1:0]  res;
  logic          borrow;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  d_q;
  logic          bo_q;

  // Difference bit of a single full-subtractor cell.
  function automatic logic sub_diff(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  // Borrow-out of a single full-subtractor cell: borrow when a < b + br.
  function automatic logic sub_borrow(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

  // Control FSM plus serial datapath; every register clears on async reset
  // so an aborted operation leaves no trace and produces no done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      d_q    <= '0;
      bo_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa     <= bus.A;
            sb     <= bus.B;
            borrow <= bus.Bin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // Result fills from the MSB end so bit 0 lands at res[0] after N shifts.
          res    <= {sub_diff(sa[0], sb[0], borrow), res[N-1:1]};
          sa     <= {1'b0, sa[N-1:1]};
          sb     <= {1'b0, sb[N-1:1]};
          borrow <= sub_borrow(sa[0], sb[0], borrow);
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          d_q    <= res;
          bo_q   <= borrow;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.Bo   = bo_q;

`ifndef SYNTHESIS
  // busy and done are mutually exclusive by construction of the FSM.
  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy_q && done_q));
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing D = A - B - Bin with a borrow-out. It is the inverse-direction companion to the team's combinational ripple-carry adder. Operands are latched on a start handshake and processed LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop. The block serves as a reusable sequential arithmetic unit and as the reference model when cross-checking the adder (A + B then - B returns A).

Parameters:
N, 4, operand and result width in bits (N >= 2)
CW, 3, bit counter width; must satisfy 2**CW > N

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request to begin a subtraction; sampled only in IDLE
A  input  N  minuend, latched on accepted start
B  input  N  subtrahend, latched on accepted start
Bin  input  1  borrow-in, latched on accepted start
busy  output  1  high while an operation is in progress (SHIFT state)
done  output  1  one-cycle pulse when D/Bo become valid
D  output  N  difference, registered
Bo  output  1  borrow-out, registered

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset value of every output and internal register is 0: busy=0, done=0, D=0, Bo=0, counter=0, state=IDLE. This holds on assertion, regardless of clock or state.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: when start=1 at a rising edge, latch A and B into shift registers sa and sb, load the borrow flop with Bin, clear the counter, and go to SHIFT. When start=0, remain in IDLE.
  - SHIFT: on each edge, with a=sa[0], b=sb[0], br=borrow:
    - d = a ^ b ^ br
    - br_next = (~a & b) | (~(a ^ b) & br)
    - Shift d into a result register from the MSB end (LSB-first fill), shift sa and sb right by 1, and set borrow <= br_next.
    - The counter increments on each edge; after N SHIFT edges, go to DONE.
  - DONE: drive D from the result register, drive Bo from the borrow flop, pulse done=1 for exactly one cycle, then return to IDLE.
- Latency: start is sampled at edge k. busy is high for cycles k+1..k+N. done is high in the cycle following edge k+N+1, so done appears N+1 edges after start (5 for N=4).
- D and Bo change only on the DONE transition. They hold their value through IDLE and through the next operation until that operation's DONE.
- start while busy=1 or in DONE is ignored: no re-latch and no effect on the operation in flight. Holding start high continuously causes a new operation to begin on the first IDLE edge after DONE.
- A, B and Bin may change freely after the accepting edge; the operation uses only the latched values.
- Arithmetic is modulo 2**N. Bo=1 exactly when A < B + Bin (unsigned), so Bo is the inverse of an adder carry in two's-complement terms.
- rst asserted mid-operation aborts immediately: all state returns to reset values and no done pulse is produced. The first edge after rst deasserts may accept a start.
- done and busy are never high in the same cycle.

Test Plan:
- Reset: assert rst during SHIFT after 2 bits -> busy, done, D and Bo drop to 0 asynchronously. Release rst, then start with A=0011, B=0001, Bin=0 -> D=0010, Bo=0, with done 5 edges after start.
- Basic cases, N=4:
  - A=0000, B=0000, Bin=0 -> D=0000, Bo=0.
  - A=0000, B=0001, Bin=0 -> D=1111, Bo=1.
  - A=0101, B=1010, Bin=0 -> D=1011, Bo=1.
- Borrow-in:
  - A=1111, B=1111, Bin=1 -> D=1111, Bo=1.
  - A=1100, B=1011, Bin=1 -> D=0000, Bo=0.
- Start while busy: start A=1010, B=0101, then pulse start with A=0001, B=0001 two cycles later -> the second start is ignored and the result is D=0101, Bo=0 with exactly one done pulse.
- Back-to-back: hold start high with constant A=1000, B=0001, Bin=0 -> repeated done pulses every N+2 cycles, D=0111, Bo=0 each time, busy low only in DONE and IDLE cycles.
- Exhaustive check: all 512 combinations of A, B and Bin for N=4 -> {Bo,D} equals (A - B - Bin) mod 32 interpreted with Bo as bit 4. Compare against a reference model, and also against the 4-bit adder round trip A + ~B + ~Bin.
